// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Build option: DMEM_ARB_FIXED_PRIO_EN selects fixed priority in place of round-robin.
package dmem_arb_pkg;

    localparam int DEF_ADDRESS_WIDTH = 16;
    localparam int DEF_DATA_WIDTH    = 32;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way combinational grant picker: round-robin on contention by default,
// plain priority encoder (port 0 first) when DMEM_ARB_FIXED_PRIO_EN is defined.
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_req,
`ifndef DMEM_ARB_FIXED_PRIO_EN
    input  logic       i_last,
`endif
    output logic       o_winner,
    output logic       o_valid
);

    always_comb begin
        o_valid = |i_req;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        o_winner = i_req[0] ? PORT_CPU : PORT_LOAD;
`else
        // On contention the port that did not win last time takes the grant.
        if (i_req == 2'b11) begin
            o_winner = ~i_last;
        end else begin
            o_winner = i_req[1] ? PORT_LOAD : PORT_CPU;
        end
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two requesters onto a single-port data memory (IDLE/ACCESS/DONE, 3 cycles per access).
// Build option: DMEM_ARB_FIXED_PRIO_EN replaces round-robin with fixed priority to port 0.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Req0,
    input  logic                     Req1,
    input  logic                     Wr0,
    input  logic                     Wr1,
    input  logic [ADDRESS_WIDTH-1:0] Addr0,
    input  logic [ADDRESS_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0]    WData0,
    input  logic [DATA_WIDTH-1:0]    WData1,
    output logic                     Ack0,
    output logic                     Ack1,
    output logic [DATA_WIDTH-1:0]    RData0,
    output logic [DATA_WIDTH-1:0]    RData1,
    output logic                     Busy,
    output logic [ADDRESS_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0]    MemWriteData,
    output logic                     MemWrite,
    input  logic [DATA_WIDTH-1:0]    MemData
);

    arb_state_t                r_state;
    arb_state_t                w_next_state;
    logic                      r_wr;
    logic [ADDRESS_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic                      r_winner;
    logic [DATA_WIDTH-1:0]     r_rdata0;
    logic [DATA_WIDTH-1:0]     r_rdata1;
    logic                      w_grant;
    logic                      w_grant_valid;
    logic                      w_take;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    rr_pick2 u_pick (
        .i_req    ({Req1, Req0}),
        .o_winner (w_grant),
        .o_valid  (w_grant_valid)
    );
`else
    logic r_last;

    rr_pick2 u_pick (
        .i_req    ({Req1, Req0}),
        .i_last   (r_last),
        .o_winner (w_grant),
        .o_valid  (w_grant_valid)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_last <= PORT_LOAD;
        end else if (w_take) begin
            r_last <= w_grant;
        end
    end
`endif

    // Requests are only looked at in IDLE; everything else ignores the request ports.
    assign w_take = (r_state == IDLE) && w_grant_valid;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_next_state = ACCESS;
            ACCESS:  w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        Busy     = (r_state != IDLE);
        MemWrite = (r_state == ACCESS) && r_wr;
        Ack0     = (r_state == DONE) && (r_winner == PORT_CPU);
        Ack1     = (r_state == DONE) && (r_winner == PORT_LOAD);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_winner <= PORT_CPU;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_take) begin
                r_winner <= w_grant;
                r_wr     <= (w_grant == PORT_LOAD) ? Wr1    : Wr0;
                r_addr   <= (w_grant == PORT_LOAD) ? Addr1  : Addr0;
                r_wdata  <= (w_grant == PORT_LOAD) ? WData1 : WData0;
            end
            // Read data is captured at the close of ACCESS; writes leave RData alone.
            if ((r_state == ACCESS) && !r_wr) begin
                if (r_winner == PORT_LOAD) begin
                    r_rdata1 <= MemData;
                end else begin
                    r_rdata0 <= MemData;
                end
            end
        end
    end

    assign MemAddress   = r_addr;
    assign MemWriteData = r_wdata;
    assign RData0       = r_rdata0;
    assign RData1       = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level model plus directed scenarios.
// Honours DMEM_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_dmem_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          Clk   = 1'b0;
    logic          Reset = 1'b1;
    logic [1:0]    req   = 2'b00;
    logic [1:0]    wr    = 2'b00;
    logic [1:0]    ack;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic [DW-1:0] rdata [2];
    logic          busy;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_data;

    logic [DW-1:0] mem   [256];
    logic [DW-1:0] g_mem [256];

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    int n_wr_cycles = 0;
    int ack_port [$];
    int ack_cyc  [$];
    bit cmp_en = 1'b0;

    dmem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Req0         (req[0]),
        .Req1         (req[1]),
        .Wr0          (wr[0]),
        .Wr1          (wr[1]),
        .Addr0        (addr[0]),
        .Addr1        (addr[1]),
        .WData0       (wdata[0]),
        .WData1       (wdata[1]),
        .Ack0         (ack[0]),
        .Ack1         (ack[1]),
        .RData0       (rdata[0]),
        .RData1       (rdata[1]),
        .Busy         (busy),
        .MemAddress   (mem_address),
        .MemWriteData (mem_wdata),
        .MemWrite     (mem_write),
        .MemData      (mem_data)
    );

    always #5 Clk = ~Clk;

    // Memory: combinational read, write committed on the negedge.
    assign mem_data = mem[mem_address[7:0]];
    always @(negedge Clk) if (mem_write) mem[mem_address[7:0]] <= mem_wdata;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    // Transaction-level model: phase 0 = waiting, 1 = memory access, 2 = completion.
    int            m_phase = 0;
    logic          m_win   = 1'b0;
    logic          m_last  = 1'b1;
    logic          m_wr    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata [2] = '{'0, '0};

    always @(posedge Clk) begin
        cycle++;
        // The mid-cycle write of an access lands even if reset arrives at its closing edge.
        if (m_phase == 1 && m_wr) g_mem[m_addr[7:0]] = m_wdata;
        if (Reset) begin
            m_phase = 0; m_last = 1'b1; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
            m_win = 1'b0; m_rdata[0] = '0; m_rdata[1] = '0;
        end else if (m_phase == 0) begin
            if (req != 2'b00) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                m_win = req[0] ? 1'b0 : 1'b1;
`else
                m_win = (req == 2'b11) ? !m_last : req[1];
`endif
                m_last  = m_win;
                m_wr    = wr[m_win];
                m_addr  = addr[m_win];
                m_wdata = wdata[m_win];
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (!m_wr) m_rdata[m_win] = g_mem[m_addr[7:0]];
            m_phase = 2;
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            check("busy",     busy,        m_phase != 0);
            check("ack0",     ack[0],      m_phase == 2 && m_win == 1'b0);
            check("ack1",     ack[1],      m_phase == 2 && m_win == 1'b1);
            check("memwrite", mem_write,   m_phase == 1 && m_wr);
            check("memaddr",  mem_address, m_addr);
            check("memwdata", mem_wdata,   m_wdata);
            check("rdata0",   rdata[0],    m_rdata[0]);
            check("rdata1",   rdata[1],    m_rdata[1]);
        end
        if (ack[0]) begin ack_port.push_back(0); ack_cyc.push_back(cycle); end
        if (ack[1]) begin ack_port.push_back(1); ack_cyc.push_back(cycle); end
        if (mem_write) n_wr_cycles++;
    end

    // Issue one request on port k; lat = negedges from raise until Ack seen.
    task automatic run_txn(input int k, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output int lat);
        bit got = 1'b0;
        lat = 0;
        req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clk);
            if (ack[k]) begin got = 1'b1; lat = n; break; end
        end
        check($sformatf("ack%0d_seen", k), got, 1);
        @(posedge Clk); #1;
        req[k] = 1'b0; wr[k] = 1'b0;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    task automatic preload(input int a, input logic [DW-1:0] v);
        mem[a] = v; g_mem[a] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, l1, n0, nack;
        int exp_order [8];
        for (int i = 0; i < 256; i++) begin mem[i] = '0; g_mem[i] = '0; end
        for (int i = 0; i < 2; i++) begin addr[i] = '0; wdata[i] = '0; end

        repeat (2) @(posedge Clk); #1;
        Reset = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_ack", ack, 0);
        check("rst_memwrite", mem_write, 0);
        check("rst_memaddr", mem_address, 0);
        check("rst_memwdata", mem_wdata, 0);
        check("rst_rdata0", rdata[0], 0);
        check("rst_rdata1", rdata[1], 0);

        // Single write then read
        n0 = n_wr_cycles;
        run_txn(0, 1'b1, 16'd5, 32'hDEADBEEF, l0);
        check("wr_latency", l0, 3);
        check("wr_cycles", n_wr_cycles - n0, 1);
        check("mem5", mem[5], 32'hDEADBEEF);
        run_txn(0, 1'b0, 16'd5, 32'h0, l0);
        check("rd_latency", l0, 3);
        check("rd_rdata0", rdata[0], 32'hDEADBEEF);

        // Contention right after reset
        preload(1, 32'd11);
        preload(2, 32'd22);
        apply_reset();
        ack_port.delete(); ack_cyc.delete();
        fork
            run_txn(0, 1'b0, 16'd1, 32'h0, l0);
            run_txn(1, 1'b0, 16'd2, 32'h0, l1);
        join
        check("cont_nacks", ack_port.size(), 2);
        if (ack_port.size() >= 2) begin
            check("cont_first", ack_port[0], 0);
            check("cont_second", ack_port[1], 1);
            check("cont_spacing", ack_cyc[1] - ack_cyc[0], 3);
        end
        check("cont_lat0", l0, 3);
        check("cont_lat1", l1, 6);
        check("cont_rdata0", rdata[0], 32'd11);
        check("cont_rdata1", rdata[1], 32'd22);

        // Sustained contention (port 1 uses high address bits to check pass-through)
        for (int i = 0; i < 4; i++) begin
            preload(16 + i, 32'h100 + i);
            preload(i, 32'h200 + i);
        end
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        apply_reset();
        ack_port.delete(); ack_cyc.delete();
        fork
            begin
                int lt;
                for (int i = 0; i < 4; i++) run_txn(0, 1'b0, AW'(16 + i), 32'h0, lt);
            end
            begin
                int lt;
                for (int i = 0; i < 4; i++) run_txn(1, 1'b0, AW'(16'hF000 + i), 32'h0, lt);
            end
        join
        check("sust_nacks", ack_port.size(), 8);
        if (ack_port.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("sust_order%0d", i), ack_port[i], exp_order[i]);
                if (i > 0) check($sformatf("sust_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);
            end
        end

        // Inputs changed during ACCESS are ignored
        preload(9, 32'hCAFE);
        fork
            run_txn(1, 1'b1, 16'd7, 32'h1234, l1);
            begin
                @(posedge Clk); #2;
                addr[1] = 16'd9; wdata[1] = 32'hFFFF;
            end
        join
        check("chg_mem7", mem[7], 32'h1234);
        check("chg_mem9", mem[9], 32'hCAFE);

        // Reset during a write ACCESS
        nack = ack_port.size();
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'd3; wdata[0] = 32'hA5A5A5A5;
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0; req[0] = 1'b0; wr[0] = 1'b0;
        check("mrst_mem3", mem[3], 32'hA5A5A5A5);
        check("mrst_busy", busy, 0);
        check("mrst_ack", ack, 0);
        check("mrst_memwrite", mem_write, 0);
        check("mrst_memaddr", mem_address, 0);
        check("mrst_memwdata", mem_wdata, 0);
        check("mrst_rdata0", rdata[0], 0);
        check("mrst_rdata1", rdata[1], 0);
        repeat (3) @(posedge Clk); #1;
        check("mrst_no_ack", ack_port.size(), nack);

        // A write leaves RData untouched
        preload(4, 32'h55);
        run_txn(0, 1'b0, 16'd4, 32'h0, l0);
        check("wnd_read", rdata[0], 32'h55);
        run_txn(0, 1'b1, 16'd4, 32'h77, l0);
        check("wnd_hold", rdata[0], 32'h55);
        check("wnd_mem4", mem[4], 32'h77);

        repeat (2) @(posedge Clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
